// File: rtl/tdm_demux_81_if.sv
// Link-side bundle for the 8:1 TDM receiver: serial beat inputs and the
// decoded frame / alignment status outputs.
interface tdm_demux_81_if #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic                i_en;
    logic                i_sync;
    logic                i_din;
    logic [SEL_W-1:0]    o_s;
    logic [CHANNELS-1:0] o_o;
    logic                o_valid;
    logic                o_locked;
    logic                o_err;

    modport master (
        output i_en, i_sync, i_din,
        input  o_s, o_o, o_valid, o_locked, o_err
    );

    modport slave (
        input  i_en, i_sync, i_din,
        output o_s, o_o, o_valid, o_locked, o_err
    );
endinterface

// File: rtl/tdm_demux_81.sv
// Receive end of the 8:1 channel-multiplex link: locks to the slot-0 sync
// marker, flywheels through missing markers and presents one word per frame.
module tdm_demux_81 #(
    parameter int CHANNELS   = 8,
    parameter int SEL_W      = 3,
    parameter int MISS_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    tdm_demux_81_if.slave     bus
);
    localparam logic [3:0]       MISS_MAX  = 4'(MISS_LIMIT);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    typedef enum logic {
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_s;
    logic [CHANNELS-1:0] r_shadow;
    logic [CHANNELS-1:0] r_o;
    logic                r_valid;
    logic                r_err;
    logic [3:0]          r_miss;

    state_t              w_stateNext;
    logic [SEL_W-1:0]    w_sNext;
    logic [CHANNELS-1:0] w_shadowNext;
    logic [CHANNELS-1:0] w_oNext;
    logic                w_validNext;
    logic                w_errNext;
    logic [3:0]          w_missNext;
    logic [3:0]          w_missInc;

    assign w_missInc = (r_miss == MISS_MAX) ? r_miss : r_miss + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_HUNT;
            r_s      <= '0;
            r_shadow <= '0;
            r_o      <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_miss   <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_s      <= w_sNext;
            r_shadow <= w_shadowNext;
            r_o      <= w_oNext;
            r_valid  <= w_validNext;
            r_err    <= w_errNext;
            r_miss   <= w_missNext;
        end
    end

    // A misplaced sync restarts the frame before any slot-7 completion is considered.
    always_comb begin
        w_stateNext  = r_state;
        w_sNext      = r_s;
        w_shadowNext = r_shadow;
        w_oNext      = r_o;
        w_validNext  = 1'b0;
        w_errNext    = 1'b0;
        w_missNext   = r_miss;
        if (bus.i_en) begin
            case (r_state)
                ST_HUNT: begin
                    if (bus.i_sync) begin
                        w_shadowNext[0] = bus.i_din;
                        w_sNext         = SLOT_ONE;
                        w_missNext      = '0;
                        w_stateNext     = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (bus.i_sync && (r_s != '0)) begin
                        w_errNext       = 1'b1;
                        w_shadowNext[0] = bus.i_din;
                        w_sNext         = SLOT_ONE;
                        w_missNext      = '0;
                    end else if (r_s == '0) begin
                        w_missNext = bus.i_sync ? 4'd0 : w_missInc;
                        if (!bus.i_sync && (w_missInc == MISS_MAX)) begin
                            w_stateNext = ST_HUNT;
                            w_sNext     = '0;
                        end else begin
                            w_shadowNext[0] = bus.i_din;
                            w_sNext         = SLOT_ONE;
                        end
                    end else begin
                        w_shadowNext[r_s] = bus.i_din;
                        w_sNext           = r_s + SLOT_ONE;
                        if (r_s == LAST_SLOT) begin
                            w_oNext     = {bus.i_din, r_shadow[CHANNELS-2:0]};
                            w_validNext = 1'b1;
                        end
                    end
                end
                default: w_stateNext = ST_HUNT;
            endcase
        end
    end

    assign bus.o_s      = r_s;
    assign bus.o_o      = r_o;
    assign bus.o_valid  = r_valid;
    assign bus.o_err    = r_err;
    assign bus.o_locked = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_tdm_demux_81.sv
// Randomized and directed bench for tdm_demux_81, checked every cycle against
// a frame-queue reference model of the link receiver.
module tb_tdm_demux_81;
    localparam int MISS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux_81_if bus ();

    tdm_demux_81 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: bits of the frame in progress, oldest first.
    bit       frameQ[$];
    bit       mLocked;
    int       mMiss;
    bit [7:0] mO;
    bit       mValid;
    bit       mErr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        frameQ.delete();
        mLocked = 1'b0;
        mMiss   = 0;
        mO      = '0;
        mValid  = 1'b0;
        mErr    = 1'b0;
    endtask

    task automatic modelStep(input bit en, input bit sync, input bit din);
        mValid = 1'b0;
        mErr   = 1'b0;
        if (!en) return;
        if (!mLocked) begin
            if (sync) begin
                frameQ.delete();
                frameQ.push_back(din);
                mLocked = 1'b1;
                mMiss   = 0;
            end
        end else if (sync && frameQ.size() != 0) begin
            mErr = 1'b1;
            frameQ.delete();
            frameQ.push_back(din);
            mMiss = 0;
        end else begin
            if (frameQ.size() == 0) begin
                if (sync) mMiss = 0;
                else if (mMiss < MISS) mMiss++;
                if (mMiss >= MISS) begin
                    mLocked = 1'b0;
                    return;
                end
            end
            frameQ.push_back(din);
            if (frameQ.size() == 8) begin
                for (int k = 0; k < 8; k++) mO[k] = frameQ[k];
                mValid = 1'b1;
                frameQ.delete();
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("s", bus.o_s, frameQ.size());
        checkOutput("o", bus.o_o, mO);
        checkOutput("valid", bus.o_valid, mValid);
        checkOutput("locked", bus.o_locked, mLocked);
        checkOutput("err", bus.o_err, mErr);
    endtask

    task automatic applyStimulus(input bit en, input bit sync, input bit din);
        @(negedge clk);
        rst        = 1'b0;
        bus.i_en   = en;
        bus.i_sync = sync;
        bus.i_din  = din;
        @(posedge clk);
        modelStep(en, sync, din);
        #1;
        compareAll();
    endtask

    task automatic applyReset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst        = 1'b1;
            bus.i_en   = 1'($urandom % 2);
            bus.i_sync = 1'($urandom % 2);
            bus.i_din  = 1'($urandom % 2);
            @(posedge clk);
            modelReset();
            #1;
            compareAll();
        end
    endtask

    task automatic idleGap(input int maxGap);
        int gap;
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        for (int g = 0; g < gap; g++)
            applyStimulus(1'b0, 1'($urandom % 2), 1'($urandom % 2));
    endtask

    task automatic sendFrame(input bit [7:0] data, input bit withSync, input int maxGap);
        for (int k = 0; k < 8; k++) begin
            idleGap(maxGap);
            applyStimulus(1'b1, withSync && (k == 0), data[k]);
        end
    endtask

    initial begin
        bus.i_en   = 1'b0;
        bus.i_sync = 1'b0;
        bus.i_din  = 1'b0;
        modelReset();

        // T1: reset then idle
        applyReset(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // T2: hunting ignores beats without sync, then lock on A5
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'($urandom % 2));
        checkOutput("t2_hunt_locked", bus.o_locked, 1'b0);
        sendFrame(8'hA5, 1'b1, 0);
        checkOutput("t2_valid", bus.o_valid, 1'b1);
        checkOutput("t2_o", bus.o_o, 8'hA5);

        // T3: back-to-back frames with idle gaps
        sendFrame(8'h3C, 1'b1, 3);
        checkOutput("t3_o1", bus.o_o, 8'h3C);
        sendFrame(8'hC3, 1'b1, 3);
        checkOutput("t3_o2", bus.o_o, 8'hC3);

        // T4: sync arrives at slot 4 while locked
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, k == 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t4_err", bus.o_err, 1'b1);
        checkOutput("t4_s", bus.o_s, 3'd1);
        checkOutput("t4_novalid", bus.o_valid, 1'b0);
        for (int k = 1; k < 8; k++) applyStimulus(1'b1, 1'b0, 1'(8'h67 >> k));
        checkOutput("t4_o", bus.o_o, 8'h67);

        // T5: flywheel through two missing markers, drop lock on the third
        sendFrame(8'hFF, 1'b1, 1);
        sendFrame(8'h12, 1'b0, 1);
        checkOutput("t5_fly1", bus.o_o, 8'h12);
        sendFrame(8'h34, 1'b0, 1);
        checkOutput("t5_fly2", bus.o_o, 8'h34);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t5_unlock", bus.o_locked, 1'b0);
        checkOutput("t5_s", bus.o_s, 3'd0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'($urandom % 2));
        sendFrame(8'h9C, 1'b1, 0);
        checkOutput("t5_relock", bus.o_o, 8'h9C);

        // T6: reset mid-frame, then a clean frame
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, k == 0, 1'b1);
        applyReset(1);
        checkOutput("t6_o_cleared", bus.o_o, 8'h00);
        sendFrame(8'h81, 1'b1, 2);
        checkOutput("t6_o", bus.o_o, 8'h81);

        // Random traffic: mostly aligned frames with occasional stray syncs and resets
        for (int f = 0; f < 40; f++) begin
            if ($urandom % 20 == 0) applyReset(1);
            for (int k = 0; k < 8; k++) begin
                idleGap(2);
                applyStimulus(1'b1,
                              (k == 0) ? ($urandom % 4 != 0) : ($urandom % 25 == 0),
                              1'($urandom % 2));
            end
        end
        for (int i = 0; i < 200; i++)
            applyStimulus(1'($urandom % 3 != 0), 1'($urandom % 6 == 0), 1'($urandom % 2));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
